stack_recursion_engine: RTL and testbench
=========================================

Name: stack_recursion_engine

Overview:
- Parametrised successor to the fixed-width Controller/Datapath recursion pair.
- Evaluates the Fibonacci recurrence f(n)=f(n-1)+f(n-2), with f(0)=0 and f(1)=1, using an explicit LIFO stack instead of hardware recursion.
- Controller FSM, stack, accumulator and status flags all live in one block, with a start/done handshake.
- Entry, result width and stack depth are parameters; stack-overflow detection and result-overflow detection are new.

Parameters:
- N_W, 4, width of entry operand and of each stack word.
- RES_W, 8, width of result accumulator.
- STACK_DEPTH, 16, number of stack entries (power of two not required).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request; sampled only in IDLE.
- entry  input  N_W  operand n; latched when start is accepted.
- busy  output  1  high from accept cycle until DONE exits.
- done  output  1  one-cycle pulse in DONE state.
- result  output  RES_W  f(n) mod 2^RES_W; held from DONE until the next accept.
- res_ovf  output  1  sticky: accumulator carry-out occurred during this run.
- stk_err  output  1  sticky: a push was attempted while the stack was full; run aborted.
- sp  output  clog2(STACK_DEPTH+1)  current stack occupancy, for debug.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, result=0, res_ovf=0, stk_err=0, sp=0. Stack contents are don't-care.
- IDLE, start=1: latch entry into n, clear acc, res_ovf, stk_err and sp; go to PUSH_INIT. busy=1 from the next cycle.
- IDLE, start=0: remain in IDLE.
- PUSH_INIT: push n, sp becomes 1; go to POP.
- POP, sp==0: go to DONE.
- POP, sp!=0: pop top value x.
  - If x<2: acc = acc + x, with carry-out setting res_ovf; stay in POP.
  - Else: tmp = x; go to EXP1.
- EXP1: push tmp-1; go to EXP2.
- EXP2: push tmp-2 (new top, so the smaller branch is processed first); go to POP.
- Any push with sp==STACK_DEPTH: no write; set stk_err; go to DONE. result then shows the partial acc.
- DONE: done=1 for exactly one cycle; result=acc; go to IDLE. start in DONE is ignored.
- start while busy: ignored, no queuing.
- Latency: cycles from the accept edge to the done cycle is L(n) = 4*F(n+1) - 1 when no stack error occurs. done is high in the cycle after those L(n) cycles.
  - L(0)=3, L(1)=3, L(6)=51.
- Arithmetic:
  - acc is RES_W wide and wraps.
  - Stack words are N_W wide; tmp-1 and tmp-2 never underflow because tmp>=2.
- Reset mid-run: immediate return to IDLE with all outputs cleared; no done pulse.
- Back-to-back: start high continuously produces a new run every L(n)+2 cycles (DONE and IDLE each take one cycle).

Optional Feature:
- Macro: STACK_RECURSION_CYCLE_COUNT_EN.
- Defined: adds output cycles [15:0], a saturating count of cycles spent busy in the last run. It is cleared on accept, frozen at DONE, and reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Default params, entry=6, start pulsed one cycle after reset release -> done 52 cycles after accept; result=8; res_ovf=0; stk_err=0; sp=0 at done.
- entry=0 and entry=1 -> done 4 cycles after accept; result=0 and 1 respectively.
- entry=13 -> result=233, res_ovf=0. Then entry=14 -> result=377 mod 256 = 121, res_ovf=1.
- STACK_DEPTH=4, entry=10 -> stk_err=1, done pulses once, busy falls, and sp never exceeds 4.
- Assert rst=0 mid-run at cycle 20 of entry=6 -> outputs clear asynchronously and no done pulse. A fresh start then gives result=8.
- start held high, entry=6 -> consecutive done pulses 53 cycles apart. start pulses while busy are ignored, and result is stable between runs.

Source files
------------

// File: rtl/stack_recursion_engine_if.sv
// stack_recursion_engine_if
// Groups the start/done handshake and the status outputs of the recursion engine.
//   start, entry          : request and operand (driven by the master)
//   busy, done, result    : run status, done pulse and f(n) mod 2^RES_W
//   res_ovf, stk_err, sp  : sticky overflow flags and stack occupancy
//   cycles                : busy-cycle count, only with STACK_RECURSION_CYCLE_COUNT_EN
// Optional feature macro: STACK_RECURSION_CYCLE_COUNT_EN
interface stack_recursion_engine_if #(
  parameter int N_W         = 4,
  parameter int RES_W       = 8,
  parameter int STACK_DEPTH = 16
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic             start;
  logic [N_W-1:0]   entry;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;
  logic             res_ovf;
  logic             stk_err;
  logic [SP_W-1:0]  sp;

`ifdef STACK_RECURSION_CYCLE_COUNT_EN
  logic [15:0]      cycles;

  modport master (
    output start, entry,
    input  busy, done, result, res_ovf, stk_err, sp, cycles
  );

  modport slave (
    input  start, entry,
    output busy, done, result, res_ovf, stk_err, sp, cycles
  );
`else
  modport master (
    output start, entry,
    input  busy, done, result, res_ovf, stk_err, sp
  );

  modport slave (
    input  start, entry,
    output busy, done, result, res_ovf, stk_err, sp
  );
`endif

endinterface

// File: rtl/stack_recursion_engine.sv
// stack_recursion_engine
// Evaluates f(n) = f(n-1) + f(n-2), f(0)=0, f(1)=1, by walking the call tree
// with an explicit LIFO stack. Every leaf (value 0 or 1) popped is added to a
// wrapping accumulator, so the final sum is f(n) mod 2^RES_W.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of stack_recursion_engine_if (start/entry in,
//         busy/done/result/res_ovf/stk_err/sp out, optional cycles out)
// Optional feature macro: STACK_RECURSION_CYCLE_COUNT_EN adds a saturating
// 16-bit count of busy cycles of the last run on bus.cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; result/flags of the previous run held
// PUSH_INIT | push the latched operand n
// POP       | pop one value; leaves accumulate, inner nodes expand
// EXP1      | push tmp-1
// EXP2      | push tmp-2 (on top, so the smaller branch is walked first)
// DONE      | one-cycle done pulse, result valid, then back to IDLE
module stack_recursion_engine #(
  parameter int N_W         = 4,
  parameter int RES_W       = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  stack_recursion_engine_if.slave bus
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_INIT,
    POP,
    EXP1,
    EXP2,
    DONE
  } state_t;

  state_t           state;
  logic [N_W-1:0]   n_q;
  logic [N_W-1:0]   tmp_q;
  logic [RES_W-1:0] acc_q;
  logic [SP_W-1:0]  sp_q;
  logic             busy_q;
  logic             done_q;
  logic [RES_W-1:0] result_q;
  logic             res_ovf_q;
  logic             stk_err_q;

  logic [N_W-1:0]   stack_mem [STACK_DEPTH];

  logic             stack_full;
  logic             push_en;
  logic [N_W-1:0]   push_data;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [N_W-1:0]   top_val;
  logic [RES_W:0]   sum;

  assign stack_full = (sp_q == SP_W'(STACK_DEPTH));
  // Writes only happen when sp < STACK_DEPTH, so the truncation is safe.
  assign wr_idx     = AW'(sp_q);
  // Read index is meaningless when sp==0; POP never uses it in that case.
  assign rd_idx     = AW'(sp_q - SP_W'(1));
  assign top_val    = stack_mem[rd_idx];
  // Only leaves (0 or 1) are ever added, so bit 0 is the whole addend.
  assign sum        = {1'b0, acc_q} + {{RES_W{1'b0}}, top_val[0]};

  always_comb begin
    push_en   = 1'b0;
    push_data = n_q;
    case (state)
      PUSH_INIT: begin
        push_en   = !stack_full;
        push_data = n_q;
      end
      EXP1: begin
        push_en   = !stack_full;
        push_data = tmp_q - N_W'(1);
      end
      EXP2: begin
        push_en   = !stack_full;
        push_data = tmp_q - N_W'(2);
      end
      default: ;
    endcase
  end

  // Stack storage carries no reset; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n_q       <= '0;
      tmp_q     <= '0;
      acc_q     <= '0;
      sp_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      res_ovf_q <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_q       <= bus.entry;
            acc_q     <= '0;
            res_ovf_q <= 1'b0;
            stk_err_q <= 1'b0;
            sp_q      <= '0;
            busy_q    <= 1'b1;
            state     <= PUSH_INIT;
          end
        end

        PUSH_INIT, EXP1, EXP2: begin
          if (stack_full) begin
            // Abort: result shows whatever was accumulated so far.
            stk_err_q <= 1'b1;
            result_q  <= acc_q;
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            sp_q  <= sp_q + SP_W'(1);
            state <= (state == EXP1) ? EXP2 : POP;
          end
        end

        POP: begin
          if (sp_q == '0) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            sp_q <= sp_q - SP_W'(1);
            if (top_val < N_W'(2)) begin
              acc_q <= sum[RES_W-1:0];
              if (sum[RES_W]) begin
                res_ovf_q <= 1'b1;
              end
            end else begin
              tmp_q <= top_val;
              state <= EXP1;
            end
          end
        end

        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef STACK_RECURSION_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  // Counts the working states only, so it freezes once DONE is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (state == IDLE && bus.start) begin
      cyc_q <= '0;
    end else if ((state == PUSH_INIT || state == POP || state == EXP1 || state == EXP2) &&
                 cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign bus.cycles = cyc_q;
`else
  // No busy-cycle counter in this build.
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.res_ovf = res_ovf_q;
  assign bus.stk_err = stk_err_q;
  assign bus.sp      = sp_q;

endmodule

// File: tb/tb_stack_recursion_engine.sv
module tb_stack_recursion_engine;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   done_main;
  int   done_small;
  int   max_sp_small;

  stack_recursion_engine_if bif ();
  stack_recursion_engine_if #(.STACK_DEPTH(4)) sif ();

  stack_recursion_engine u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bif.slave)
  );

  stack_recursion_engine #(.STACK_DEPTH(4)) u_small (
    .clk (clk),
    .rst (rst_n),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bif.done) done_main++;
    if (sif.done) done_small++;
    if (int'(sif.sp) > max_sp_small) max_sp_small = int'(sif.sp);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run on the default instance; lat is done-cycle minus accept-cycle.
  task automatic run_main(input logic [3:0] n, input int budget, output int lat);
    int t0;
    bit seen;
    @(negedge clk);
    bif.start = 1'b1;
    bif.entry = n;
    t0 = cyc;
    @(negedge clk);
    bif.start = 1'b0;
    check("busy_after_accept", bif.busy, 1);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bif.done) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else begin
        @(negedge clk);
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("busy_in_done", bif.busy, 1);
      @(negedge clk);
      check("done_one_cycle", bif.done, 0);
      check("busy_after_done", bif.busy, 0);
    end
  endtask

  initial begin
    int lat;
    int t0;
    int d0;
    int bad;
    int ndone;
    int tdone [3];
    bit seen;

    n_checks     = 0;
    n_errors     = 0;
    done_main    = 0;
    done_small   = 0;
    max_sp_small = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bif.start    = 1'b0;
    bif.entry    = '0;
    sif.start    = 1'b0;
    sif.entry    = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",    bif.busy, 0);
    check("rst_done",    bif.done, 0);
    check("rst_result",  bif.result, 0);
    check("rst_res_ovf", bif.res_ovf, 0);
    check("rst_stk_err", bif.stk_err, 0);
    check("rst_sp",      bif.sp, 0);
    rst_n = 1'b1;

    // entry=6: f=8, L=51 -> done 52 cycles after the accept cycle
    run_main(4'd6, 200, lat);
    check("lat_6",     lat, 52);
    check("result_6",  bif.result, 8);
    check("ovf_6",     bif.res_ovf, 0);
    check("stkerr_6",  bif.stk_err, 0);
    check("sp_6",      bif.sp, 0);
`ifdef STACK_RECURSION_CYCLE_COUNT_EN
    check("cycles_6",  bif.cycles, 51);
`endif

    run_main(4'd0, 50, lat);
    check("lat_0",    lat, 4);
    check("result_0", bif.result, 0);

    run_main(4'd1, 50, lat);
    check("lat_1",    lat, 4);
    check("result_1", bif.result, 1);

    // f(13)=233 fits; L = 4*F(14)-1 = 1507
    run_main(4'd13, 3000, lat);
    check("lat_13",    lat, 1508);
    check("result_13", bif.result, 233);
    check("ovf_13",    bif.res_ovf, 0);

    // f(14)=377 -> 121 with carry; L = 4*F(15)-1 = 2439
    run_main(4'd14, 3000, lat);
    check("lat_14",    lat, 2440);
    check("result_14", bif.result, 121);
    check("ovf_14",    bif.res_ovf, 1);

    // Depth-4 stack, entry=10: overflow on the push of 2 in EXP2, cycle 14
    @(negedge clk);
    sif.start = 1'b1;
    sif.entry = 4'd10;
    t0 = cyc;
    @(negedge clk);
    sif.start = 1'b0;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (sif.done) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else begin
        @(negedge clk);
      end
    end
    check("small_done_seen", seen, 1);
    check("small_lat",       lat, 14);
    check("small_stk_err",   sif.stk_err, 1);
    check("small_result",    sif.result, 0);
    check("small_sp",        sif.sp, 4);
    repeat (4) @(negedge clk);
    #1;
    check("small_done_cnt",  done_small, 1);
    check("small_busy_fall", sif.busy, 0);
    check("small_max_sp",    max_sp_small, 4);

    // Reset at cycle 20 of an entry=6 run
    @(negedge clk);
    bif.start = 1'b1;
    bif.entry = 4'd6;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_busy", bif.busy, 1);
    d0 = done_main;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   bif.busy, 0);
    check("mid_rst_result", bif.result, 0);
    check("mid_rst_sp",     bif.sp, 0);
    check("mid_rst_done",   bif.done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mid_no_done",    done_main, d0);
    check("mid_idle_busy",  bif.busy, 0);
    run_main(4'd6, 200, lat);
    check("post_rst_lat",    lat, 52);
    check("post_rst_result", bif.result, 8);

    // start held high: runs every L+2 = 53 cycles, result steady at 8
    @(negedge clk);
    bif.start = 1'b1;
    bif.entry = 4'd6;
    ndone = 0;
    bad   = 0;
    for (int i = 0; i < 400 && ndone < 3; i++) begin
      if (bif.result != 8'd8) bad++;
      if (bif.done) begin
        tdone[ndone] = cyc;
        ndone++;
        if (ndone == 3) bif.start = 1'b0;
      end
      if (ndone < 3) @(negedge clk);
    end
    check("b2b_count", ndone, 3);
    if (ndone == 3) begin
      check("b2b_gap1", tdone[1] - tdone[0], 53);
      check("b2b_gap2", tdone[2] - tdone[1], 53);
    end
    check("b2b_result_stable", bad, 0);
    repeat (3) @(negedge clk);
    check("b2b_idle", bif.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
